alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Parametrised execute-stage ALU for the pipelined core. Adds RV32M multiply/divide and unsigned compare to the
//  base integer op set. Single-cycle ops, a multi-cycle multiplier and an iterative divider share one
//  valid/ready front end. The hazard unit stalls the pipeline on !in_ready and takes the result on out_valid.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, power of 2); SHW = $clog2(XLEN) localparam
//  MUL_CYCLES   2  multiply latency in cycles after accept (1..4); models a retimed multiplier
// PORTS
//  clk         in   1     clock, all state on rising edge
//  reset       in   1     synchronous, active-high
//  flush       in   1     abort in-flight op (branch mispredict), no result produced
//  in_valid    in   1     op request
//  in_ready    out  1     block idle, can accept
//  alucontrol  in   5     operation code (see BEHAVIOUR)
//  scra        in   XLEN  operand A
//  scrb        in   XLEN  operand B
//  out_valid   out  1     aluresult valid
//  out_ready   in   1     consumer takes result
//  aluresult   out  XLEN  result
//  busy        out  1     MUL or DIV state active (stall hint)
// BEHAVIOUR
//  Codes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 slt (signed), 00110 sltu,
//   00111 sll, 01000 srl, 01001 sra; 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu,
//   10100 div, 10101 divu, 10110 rem, 10111 remu; any other code -> result 0, single-cycle path.
//  Shifts use scrb[SHW-1:0]. slt/sltu give {XLEN-1 zeros, bit}. Wrap-around on add/sub/mul, no flags.
//  FSM IDLE -> {DONE | MUL | DIV}; accept = in_valid & in_ready; in_ready = (state==IDLE) & !reset.
//   IDLE: on accept, latch operands + op. Single-cycle op -> DONE. Mul op -> MUL, cnt = MUL_CYCLES-1.
//    Div op -> DIV, except special cases below, which go straight to DONE.
//   MUL: cnt decrements; at cnt==0 -> DONE. Result = low (mul) or high XLEN bits of 2*XLEN product.
//    mulh is signed x signed, mulhsu is signed A x unsigned B, mulhu is unsigned x unsigned.
//   DIV: restoring divider on magnitudes, one quotient bit per cycle, XLEN cycles, then sign fix-up -> DONE.
//    Signed quotient is negated iff sign(A)!=sign(B); remainder takes sign of A.
//   DONE: out_valid=1, aluresult stable; out_ready -> IDLE. Result held while !out_ready.
//  Latency accept->out_valid: 1 cycle single-cycle, MUL_CYCLES+1 mul, XLEN+2 div, 1 special-case div.
//  Div special cases:
//   - B==0: quotient = all-ones; remainder = A.
//   - signed A==most-negative & B==-1: quotient = A; remainder = 0.
//  No new accept in DONE, even with out_ready high (one-bubble turnaround); re-accept earliest next cycle.
//  flush: any state -> IDLE next cycle; out_valid deasserts; in_valid ignored same cycle.
//  Reset mid-operation behaves as flush plus outputs cleared.
//  Reset values: state IDLE, out_valid 0, aluresult 0, busy 0, in_ready 0 while reset high.
//  Inputs scra/scrb/alucontrol may change after accept without affecting the in-flight op.
// STRUCTURE
//  alu_pkg: alu_op_e (5-bit enum, codes above), alu_state_e {IDLE,MUL,DIV,DONE},
//   is_mul()/is_div() helper functions, XLEN default constant.
//  Sub-module alu_divider (XLEN param): start, signed_op, a, b -> done, quot, rem; owns the iteration
//   counter and fix-up; top FSM owns handshake, special cases, mul pipeline and single-cycle mux.
// TESTING
//  add 0x7FFFFFFF+1 -> 0x80000000 one cycle after accept; sra 0x80000000 by 0x21 (uses 1) -> 0xC0000000.
//  slt -1,1 -> 1; sltu 0xFFFFFFFF,1 -> 0; illegal code 11111 -> 0, out_valid after 1 cycle.
//  mulh 0x80000000*0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF^2 -> 0xFFFFFFFE;
//   out_valid exactly MUL_CYCLES+1 after accept, in_ready low meanwhile.
//  div -7/2 -> -3, rem -7/2 -> -1 after XLEN+2 cycles; divu 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5;
//   div 0x80000000/-1 -> 0x80000000 in 1 cycle; rem of same -> 0.
//  out_ready held low 5 cycles in DONE -> aluresult stable, in_ready 0; release -> IDLE, next accept ok.
//  flush in cycle 10 of div -> no out_valid, in_ready 1 next cycle; reset mid-mul -> all outputs at reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the execute-stage ALU with RV32M multiply/divide.
package alu_pkg;

    localparam int unsigned ALU_XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_AND    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SLT    = 5'b00101,
        OP_SLTU   = 5'b00110,
        OP_SLL    = 5'b00111,
        OP_SRL    = 5'b01000,
        OP_SRA    = 5'b01001,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle plus sign fix-up.
module alu_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            abort_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_c,
    output logic [XLEN-1:0] quot_c,
    output logic [XLEN-1:0] rem_c
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic            run_q, run_d, fix_q, fix_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic [XLEN:0]   shifted, diff;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        run_d  = run_q;
        fix_d  = fix_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        if (start_i) begin
            run_d  = 1'b1;
            fix_d  = 1'b0;
            cnt_d  = CW'(XLEN);
            quo_d  = (signed_i && a_i[XLEN-1]) ? XLEN'(0) - a_i : a_i;
            dvs_d  = (signed_i && b_i[XLEN-1]) ? XLEN'(0) - b_i : b_i;
            rem_d  = '0;
            negq_d = signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
            negr_d = signed_i & a_i[XLEN-1];
        end else if (run_q) begin
            // Restore when the trial subtraction borrows.
            if (diff[XLEN]) begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d = 1'b0;
                fix_d = 1'b1;
            end
        end else if (fix_q) begin
            fix_d = 1'b0;
        end
        if (abort_i) begin
            run_d = 1'b0;
            fix_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            fix_q  <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            fix_q  <= fix_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign done_c = fix_q;
    assign quot_c = negq_q ? XLEN'(0) - quo_q : quo_q;
    assign rem_c  = negr_q ? XLEN'(0) - rem_q : rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle integer ops, multi-cycle multiply and iterative divide behind one handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = ALU_XLEN,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alucontrol,
    input  logic [XLEN-1:0] scra,
    input  logic [XLEN-1:0] scrb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluresult,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = 2;

    alu_state_e      state_q, state_d;
    alu_op_e         op_q, op_d, op_in;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d, single_res;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, busy_q;
    logic            accept, div_start, div_signed, div_done;
    logic [XLEN-1:0] div_quot, div_rem;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic [XLEN-1:0] mul_res;

    assign op_in      = alu_op_e'(alucontrol);
    assign in_ready   = (state_q == ST_IDLE) && !reset;
    assign accept     = in_valid && in_ready && !flush;
    assign div_signed = (op_in == OP_DIV) || (op_in == OP_REM);

    // Sign-extend latched operands so one 2*XLEN product serves all four multiply flavours.
    assign ext_a   = {{XLEN{a_q[XLEN-1] & (op_q == OP_MULH || op_q == OP_MULHSU)}}, a_q};
    assign ext_b   = {{XLEN{b_q[XLEN-1] & (op_q == OP_MULH)}}, b_q};
    assign prod    = ext_a * ext_b;
    assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        single_res = '0;
        case (op_in)
            OP_ADD:  single_res = scra + scrb;
            OP_SUB:  single_res = scra - scrb;
            OP_AND:  single_res = scra & scrb;
            OP_OR:   single_res = scra | scrb;
            OP_XOR:  single_res = scra ^ scrb;
            OP_SLT:  single_res = XLEN'($signed(scra) < $signed(scrb));
            OP_SLTU: single_res = XLEN'(scra < scrb);
            OP_SLL:  single_res = scra << scrb[SHW-1:0];
            OP_SRL:  single_res = scra >> scrb[SHW-1:0];
            OP_SRA:  single_res = $signed(scra) >>> scrb[SHW-1:0];
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = op_in;
                    a_d  = scra;
                    b_d  = scrb;
                    if (is_mul(alucontrol)) begin
                        state_d = ST_MUL;
                        cnt_d   = CW'(MUL_CYCLES - 1);
                    end else if (is_div(alucontrol)) begin
                        // Divide-by-zero and signed overflow resolve without iterating.
                        if (scrb == '0) begin
                            res_d   = alucontrol[1] ? scra : '1;
                            state_d = ST_DONE;
                        end else if (div_signed && scra == {1'b1, {(XLEN-1){1'b0}}} && &scrb) begin
                            res_d   = alucontrol[1] ? '0 : scra;
                            state_d = ST_DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                    end else begin
                        res_d   = single_res;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    res_d   = mul_res;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    res_d   = op_q[1] ? div_rem : div_quot;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_MUL) || (state_d == ST_DIV);
        end
    end

    alu_divider #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .reset    (reset),
        .abort_i  (flush),
        .start_i  (div_start),
        .signed_i (div_signed),
        .a_i      (scra),
        .b_i      (scrb),
        .done_c   (div_done),
        .quot_c   (div_quot),
        .rem_c    (div_rem)
    );

    assign out_valid = out_valid_q;
    assign aluresult = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32, MUL_CYCLES=2).
module tb_alu_muldiv;

    localparam int unsigned XLEN    = 32;
    localparam int          LAT_MUL = 3;
    localparam int          LAT_DIV = 34;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]      alucontrol;
    logic [XLEN-1:0] scra, scrb, aluresult;

    int checks   = 0;
    int failures = 0;

    alu_muldiv #(.XLEN(XLEN), .MUL_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .scra       (scra),
        .scrb       (scrb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluresult  (aluresult),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, then measure latency and result.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp);
        int   n;
        logic ir_seen;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        alucontrol = op; scra = a; scrb = b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; alucontrol = 5'b00000; scra = ~a; scrb = ~b;
        n = 1;
        ir_seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) ir_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, aluresult, exp);
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        if (exp_lat > 1) chk({tag, "_busy_stall"}, 32'(ir_seen), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alucontrol = '0; scra = '0; scrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", aluresult, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;

        do_op("add_ovf", 5'b00000, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000);
        do_op("sub",     5'b00001, 32'd5,        32'd7,        1, 32'hFFFFFFFE);
        do_op("and",     5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000);
        do_op("or",      5'b00011, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hFFF0FFF0);
        do_op("xor",     5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0);
        do_op("slt",     5'b00101, 32'hFFFFFFFF, 32'd1,        1, 32'd1);
        do_op("sltu",    5'b00110, 32'hFFFFFFFF, 32'd1,        1, 32'd0);
        do_op("sll",     5'b00111, 32'd1,        32'h24,       1, 32'h10);
        do_op("srl",     5'b01000, 32'h80000000, 32'd4,        1, 32'h08000000);
        do_op("sra",     5'b01001, 32'h80000000, 32'h21,       1, 32'hC0000000);
        do_op("illegal", 5'b11111, 32'h12345678, 32'h9ABCDEF0, 1, 32'd0);

        do_op("mul",     5'b10000, 32'd7,        32'hFFFFFFFD, LAT_MUL, 32'hFFFFFFEB);
        do_op("mulh",    5'b10001, 32'h80000000, 32'h80000000, LAT_MUL, 32'h40000000);
        do_op("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, 32'hFFFFFFFF);
        do_op("mulhu",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, 32'hFFFFFFFE);

        do_op("div",     5'b10100, 32'hFFFFFFF9, 32'd2,        LAT_DIV, 32'hFFFFFFFD);
        do_op("rem",     5'b10110, 32'hFFFFFFF9, 32'd2,        LAT_DIV, 32'hFFFFFFFF);
        do_op("divu",    5'b10101, 32'd100,      32'd7,        LAT_DIV, 32'd14);
        do_op("remu",    5'b10111, 32'd100,      32'd7,        LAT_DIV, 32'd2);
        do_op("divu_z",  5'b10101, 32'd5,        32'd0,        1,       32'hFFFFFFFF);
        do_op("rem_z",   5'b10110, 32'd5,        32'd0,        1,       32'd5);
        do_op("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 1,       32'h80000000);
        do_op("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 1,       32'd0);

        // Consumer back-pressure in DONE.
        @(negedge clk);
        alucontrol = 5'b00000; scra = 32'd40; scrb = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; scra = '0;
        held = aluresult;
        chk("hold_first", held, 32'd42);
        repeat (5) begin
            @(negedge clk);
            chk("hold_result", aluresult, 32'd42);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        do_op("after_hold", 5'b00001, 32'd10, 32'd3, 1, 32'd7);

        // Flush during divide.
        @(negedge clk);
        alucontrol = 5'b10101; scra = 32'd1000; scrb = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        do_op("after_flush", 5'b10101, 32'd1000, 32'd3, LAT_DIV, 32'd333);

        // Reset mid-multiply.
        @(negedge clk);
        alucontrol = 5'b10000; scra = 32'd6; scrb = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmul_valid", 32'(out_valid), 32'd0);
        chk("rstmul_result", aluresult, 32'd0);
        chk("rstmul_busy", 32'(busy), 32'd0);
        chk("rstmul_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rstmul_no_result", 32'(out_valid), 32'd0);
        end
        do_op("after_reset", 5'b10000, 32'd6, 32'd7, LAT_MUL, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
